// File: rtl/result_pkg.sv
// Shared types and helpers for the result decimator: FSM state encoding and
// the channel-index width rule.
package result_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dec_state_t;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/result_if.sv
// Result stream bundle: wide per-beat input vector in, channel-serialised words out.
// master = decimator side, slave = producer/consumer side.
interface result_if
    import result_pkg::*;
#(
    parameter int OUT_WIDTH = 24,
    parameter int CHANNELS  = 1
);
    localparam int CHAN_W = chan_w(CHANNELS);

    logic [CHANNELS*OUT_WIDTH-1:0] in_data;
    logic                          in_valid;
    logic [OUT_WIDTH-1:0]          out_data;
    logic [CHAN_W-1:0]             out_chan;
    logic                          out_valid;
    logic                          out_ready;
    logic                          overflow;
    logic                          done;

    modport master (
        input  in_data, in_valid, out_ready,
        output out_data, out_chan, out_valid, overflow, done
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  out_data, out_chan, out_valid, overflow, done
    );
endinterface

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO holding whole kept beats; head is valid whenever
// !empty. Push and pop in the same cycle while full is legal.
module result_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/result_decimator.sv
// Keeps one input beat in every OSR, buffers it, and serialises its channels on a
// valid/ready stream until FRAME_LEN beats are seen. RESULT_SIGNED_CONV_EN converts
// offset-binary results to two's complement at the output.
module result_decimator
    import result_pkg::*;
#(
    parameter int OUT_WIDTH  = 24,
    parameter int OSR        = 1,
    parameter int CHANNELS   = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_LEN  = 24000
) (
    input logic      clk,
    input logic      rst,
    result_if.master bus
);
    localparam int                CHAN_W    = chan_w(CHANNELS);
    localparam int                PH_W      = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int                VEC_W     = CHANNELS * OUT_WIDTH;
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(OSR - 1);
    localparam logic [31:0]       LAST_BEAT = 32'(FRAME_LEN - 1);

    dec_state_t        state;
    dec_state_t        state_nxt;
    logic [PH_W-1:0]   phase;
    logic [31:0]       beat_cnt;
    logic [CHAN_W-1:0] chan_idx;
    logic              overflow_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [VEC_W-1:0]  fifo_head;
    logic              accept;
    logic              keep;
    logic              handshake;
    logic              pop;
    logic              push;
    logic              last_beat;

    function automatic logic [OUT_WIDTH-1:0] chan_slice(input logic [VEC_W-1:0] vec,
                                                        input logic [CHAN_W-1:0] idx);
        return vec[idx*OUT_WIDTH +: OUT_WIDTH];
    endfunction

    function automatic logic [OUT_WIDTH-1:0] to_output(input logic [OUT_WIDTH-1:0] r);
`ifdef RESULT_SIGNED_CONV_EN
        return {~r[OUT_WIDTH-1], r[OUT_WIDTH-2:0]};
`else
        return r;
`endif
    endfunction

    assign accept    = bus.in_valid && (state == IDLE || state == RUN);
    assign keep      = accept && (phase == '0);
    assign handshake = !fifo_empty && bus.out_ready;
    assign pop       = handshake && (chan_idx == LAST_CHAN);
    // A full FIFO can still take the beat if its head leaves on this same edge.
    assign push      = keep && (!fifo_full || pop);
    assign last_beat = (FRAME_LEN != 0) && accept && (beat_cnt == LAST_BEAT);

    result_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.in_valid) state_nxt = last_beat ? DRAIN : RUN;
            RUN:   if (last_beat)    state_nxt = DRAIN;
            DRAIN: if (fifo_empty)   state_nxt = DONE;
            DONE:  state_nxt = DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= '0;
            beat_cnt   <= '0;
            chan_idx   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                phase    <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (handshake) chan_idx <= (chan_idx == LAST_CHAN) ? '0 : chan_idx + 1'b1;
            if (keep && !push) overflow_q <= 1'b1;
        end
    end

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : to_output(chan_slice(fifo_head, chan_idx));
    assign bus.out_chan  = chan_idx;
    assign bus.overflow  = overflow_q;
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_result_decimator.sv
// Bench for result_decimator: three configurations driven by directed vectors and
// checked every cycle against a queue-based model of the keep/serialise rules.
module tb_result_decimator;

    localparam int M_OSR   [3] = '{1, 3, 2};
    localparam int M_CH    [3] = '{1, 1, 2};
    localparam int M_DEPTH [3] = '{8, 8, 2};
    localparam int M_LEN   [3] = '{4, 9, 0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    result_if #(.OUT_WIDTH(24), .CHANNELS(1)) ia ();
    result_if #(.OUT_WIDTH(24), .CHANNELS(1)) ib ();
    result_if #(.OUT_WIDTH(24), .CHANNELS(2)) ic ();

    result_decimator #(.OUT_WIDTH(24), .OSR(1), .CHANNELS(1), .FIFO_DEPTH(8), .FRAME_LEN(4))
        u_a (.clk(clk), .rst(rst), .bus(ia));
    result_decimator #(.OUT_WIDTH(24), .OSR(3), .CHANNELS(1), .FIFO_DEPTH(8), .FRAME_LEN(9))
        u_b (.clk(clk), .rst(rst), .bus(ib));
    result_decimator #(.OUT_WIDTH(24), .OSR(2), .CHANNELS(2), .FIFO_DEPTH(2), .FRAME_LEN(0))
        u_c (.clk(clk), .rst(rst), .bus(ic));

    int checks = 0;
    int errors = 0;

    // model state, one slot per instance
    logic [47:0] m_buf   [3][8];
    int          m_rd    [3];
    int          m_cnt   [3];
    int          m_cp    [3];
    int          m_beat  [3];
    bit          m_drain [3];
    bit          m_done  [3];
    bit          m_ovf   [3];

    // handshake log of what each DUT actually delivered
    logic [23:0] log_d [3][16];
    int          log_c [3][16];
    int          log_n [3];

    function automatic logic [23:0] conv(input logic [23:0] r);
`ifdef RESULT_SIGNED_CONV_EN
        return {~r[23], r[22:0]};
`else
        return r;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input logic iv, input logic [47:0] id,
                              input logic rdy, input logic ov, input logic [23:0] od,
                              input int oc, input logic ovf, input logic dn);
        logic [47:0] head;
        bit hs, pop_last, accept, kept;
        int pre_cnt;
        if (!rst) begin
            chk($sformatf("rst_valid_u%0d", i), ov, 0);
            chk($sformatf("rst_data_u%0d", i), od, 0);
            chk($sformatf("rst_chan_u%0d", i), oc, 0);
            chk($sformatf("rst_ovf_u%0d", i), ovf, 0);
            chk($sformatf("rst_done_u%0d", i), dn, 0);
            m_rd[i] = 0; m_cnt[i] = 0; m_cp[i] = 0; m_beat[i] = 0;
            m_drain[i] = 0; m_done[i] = 0; m_ovf[i] = 0; log_n[i] = 0;
            return;
        end
        chk($sformatf("valid_u%0d", i), ov, (m_cnt[i] > 0));
        if (m_cnt[i] > 0) begin
            head = m_buf[i][m_rd[i]];
            chk($sformatf("data_u%0d", i), od, conv(head[m_cp[i]*24 +: 24]));
            chk($sformatf("chan_u%0d", i), oc, m_cp[i]);
        end
        chk($sformatf("overflow_u%0d", i), ovf, m_ovf[i]);
        chk($sformatf("done_u%0d", i), dn, m_done[i]);
        if (ov && rdy && log_n[i] < 16) begin
            log_d[i][log_n[i]] = od;
            log_c[i][log_n[i]] = oc;
            log_n[i]++;
        end
        // predict the effect of the coming edge
        pre_cnt  = m_cnt[i];
        hs       = (pre_cnt > 0) && rdy;
        pop_last = hs && (m_cp[i] == M_CH[i] - 1);
        accept   = iv && !m_drain[i] && !m_done[i];
        kept     = accept && (m_beat[i] % M_OSR[i] == 0);
        if (m_drain[i] && pre_cnt == 0) m_done[i] = 1;
        if (hs) begin
            if (pop_last) begin
                m_rd[i] = (m_rd[i] + 1) % 8;
                m_cnt[i]--;
                m_cp[i] = 0;
            end else begin
                m_cp[i]++;
            end
        end
        if (kept) begin
            if (pre_cnt < M_DEPTH[i] || pop_last) begin
                m_buf[i][(m_rd[i] + m_cnt[i]) % 8] = id;
                m_cnt[i]++;
            end else begin
                m_ovf[i] = 1;
            end
        end
        if (accept) begin
            if (M_LEN[i] != 0 && m_beat[i] == M_LEN[i] - 1) m_drain[i] = 1;
            m_beat[i]++;
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            model_step(0, ia.in_valid, 48'(ia.in_data), ia.out_ready, ia.out_valid,
                       ia.out_data, int'(ia.out_chan), ia.overflow, ia.done);
            model_step(1, ib.in_valid, 48'(ib.in_data), ib.out_ready, ib.out_valid,
                       ib.out_data, int'(ib.out_chan), ib.overflow, ib.done);
            model_step(2, ic.in_valid, ic.in_data, ic.out_ready, ic.out_valid,
                       ic.out_data, int'(ic.out_chan), ic.overflow, ic.done);
        end
    endtask

    function automatic logic get_done(input int i);
        case (i)
            0:       return ia.done;
            1:       return ib.done;
            default: return ic.done;
        endcase
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        ia.in_valid = 0; ib.in_valid = 0; ic.in_valid = 0;
        ia.out_ready = 0; ib.out_ready = 0; ic.out_ready = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic wait_done(input int i, input int limit);
        int n = 0;
        while (get_done(i) !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_done_u%0d", i), get_done(i), 1);
    endtask

    initial begin
        ia.in_data = '0; ib.in_data = '0; ic.in_data = '0;
        ia.in_valid = 0; ib.in_valid = 0; ic.in_valid = 0;
        ia.out_ready = 0; ib.out_ready = 0; ic.out_ready = 0;
        fork
            compare_loop();
        join_none

        // OSR=1, CH=1, LEN=4: every beat out one cycle after its push
        do_reset();
        ia.out_ready = 1;
        @(posedge clk); #1 ia.in_valid = 1; ia.in_data = 24'd1;
        @(negedge clk); chk("a_lat_before_push", ia.out_valid, 0);
        @(posedge clk); #1 ia.in_data = 24'd2;
        @(negedge clk); chk("a_lat_after_push", ia.out_valid, 1);
        chk("a_first_word", ia.out_data, conv(24'd1));
        @(posedge clk); #1 ia.in_data = 24'd3;
        @(posedge clk); #1 ia.in_data = 24'd4;
        @(posedge clk); #1 ia.in_valid = 0;
        wait_done(0, 20);
        chk("a_count", log_n[0], 4);
        for (int k = 0; k < 4; k++) chk($sformatf("a_word%0d", k), log_d[0][k], conv(24'(k + 1)));
        @(posedge clk); #1 ia.in_valid = 1; ia.in_data = 24'h99;
        @(posedge clk); #1 ia.in_valid = 0;
        repeat (2) @(negedge clk);
        chk("a_done_ignores_input", ia.out_valid, 0);
        chk("a_done_held", ia.done, 1);

        // output conversion on extreme codes
        do_reset();
        ia.out_ready = 1;
        @(posedge clk); #1 ia.in_valid = 1; ia.in_data = 24'h800000;
        @(posedge clk); #1 ia.in_data = 24'h000001;
        @(posedge clk); #1 ia.in_valid = 0;
        repeat (4) @(negedge clk);
        chk("conv_count", log_n[0], 2);
`ifdef RESULT_SIGNED_CONV_EN
        chk("conv_min", log_d[0][0], 24'h000000);
        chk("conv_one", log_d[0][1], 24'h800001);
`else
        chk("conv_min", log_d[0][0], 24'h800000);
        chk("conv_one", log_d[0][1], 24'h000001);
`endif

        // reset mid-frame with two buffered beats
        do_reset();
        @(posedge clk); #1 ia.in_valid = 1; ia.in_data = 24'h11;
        @(posedge clk); #1 ia.in_data = 24'h22;
        @(posedge clk); #1 ia.in_valid = 0;
        @(negedge clk); chk("r_buffered", ia.out_valid, 1);
        @(posedge clk); #3 rst = 1'b0;
        #1 chk("r_valid_immediate", ia.out_valid, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1; ia.out_ready = 1;
        repeat (3) @(negedge clk);
        chk("r_no_stale", ia.out_valid, 0);
        chk("r_done", ia.done, 0);
        chk("r_overflow", ia.overflow, 0);
        chk("r_log_empty", log_n[0], 0);
        @(posedge clk); #1 ia.in_valid = 1; ia.in_data = 24'h55;
        @(posedge clk); #1 ia.in_valid = 0;
        repeat (3) @(negedge clk);
        chk("r_fresh_count", log_n[0], 1);
        chk("r_fresh_word", log_d[0][0], conv(24'h55));

        // OSR=3, LEN=9: back-to-back beats, then the same with gaps
        for (int gap = 0; gap < 2; gap++) begin
            do_reset();
            ib.out_ready = 1;
            for (int v = 10; v <= 18; v++) begin
                @(posedge clk); #1 ib.in_valid = 1; ib.in_data = 24'(v);
                if (gap != 0) begin
                    @(posedge clk); #1 ib.in_valid = 0;
                end
            end
            @(posedge clk); #1 ib.in_valid = 0;
            wait_done(1, 20);
            chk($sformatf("b_count_gap%0d", gap), log_n[1], 3);
            chk($sformatf("b_w0_gap%0d", gap), log_d[1][0], conv(24'd10));
            chk($sformatf("b_w1_gap%0d", gap), log_d[1][1], conv(24'd13));
            chk($sformatf("b_w2_gap%0d", gap), log_d[1][2], conv(24'd16));
        end

        // CH=2: channel order and hold under backpressure
        do_reset();
        @(posedge clk); #1 ic.in_valid = 1; ic.in_data = {24'hB, 24'hA};
        @(posedge clk); #1 ic.in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("c_hold_valid%0d", k), ic.out_valid, 1);
            chk($sformatf("c_hold_data%0d", k), ic.out_data, conv(24'hA));
            chk($sformatf("c_hold_chan%0d", k), ic.out_chan, 0);
        end
        @(posedge clk); #1 ic.out_ready = 1;
        repeat (4) @(negedge clk);
        chk("c_count", log_n[2], 2);
        chk("c_w0", log_d[2][0], conv(24'hA));
        chk("c_c0", log_c[2][0], 0);
        chk("c_w1", log_d[2][1], conv(24'hB));
        chk("c_c1", log_c[2][1], 1);

        // depth 2, stalled consumer: third kept beat is dropped
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1 ic.in_valid = 1; ic.in_data = {24'(16*k + 1), 24'(16*k)};
        end
        @(posedge clk); #1 ic.in_valid = 0;
        @(negedge clk); chk("o_overflow_set", ic.overflow, 1);
        @(posedge clk); #1 ic.out_ready = 1;
        repeat (8) @(negedge clk);
        chk("o_count", log_n[2], 4);
        chk("o_second_beat", log_d[2][2], conv(24'h20));
        chk("o_sticky", ic.overflow, 1);

        // same, but the head's last channel leaves on the third push
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 ic.in_valid = 1; ic.in_data = {24'(16*k + 1), 24'(16*k)};
        end
        @(posedge clk); #1 ic.in_valid = 0; ic.out_ready = 1;
        @(posedge clk); #1 ic.in_valid = 1; ic.in_data = {24'h41, 24'h40};
        @(posedge clk); #1 ic.in_valid = 0;
        repeat (8) @(negedge clk);
        chk("p_no_overflow", ic.overflow, 0);
        chk("p_count", log_n[2], 6);
        chk("p_third_beat", log_d[2][4], conv(24'h40));
        chk("p_third_chan1", log_d[2][5], conv(24'h41));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
